// File: rtl/joy_serial_multi_if.sv
// Joystick front-end bus: the core side (master) drives enable and the
// register chain returns joy_data; the reader (slave) drives the register
// control lines and presents the debounced button vector with its strobes.
interface joy_serial_multi_if #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12
);
  logic                    enable;
  logic                    joy_load_n;
  logic                    joy_clk;
  logic                    joy_data;
  logic [PLAYERS*BITS-1:0] joystick;
  logic                    valid;
  logic                    changed;
  logic                    scan_busy;

  modport master (
    output enable,
    output joy_data,
    input  joy_load_n,
    input  joy_clk,
    input  joystick,
    input  valid,
    input  changed,
    input  scan_busy
  );

  modport slave (
    input  enable,
    input  joy_data,
    output joy_load_n,
    output joy_clk,
    output joystick,
    output valid,
    output changed,
    output scan_busy
  );
endinterface

// File: rtl/joy_serial_multi.sv
// Serial joystick reader for daisy-chained 74HC165-style registers.
// Loads the chain, shifts PLAYERS*BITS bits (each player MSB first, player 0
// first), optionally debounces over several scans and presents an
// active-high button vector with per-scan valid/changed strobes.
module joy_serial_multi #(
  parameter int PLAYERS    = 2,
  parameter int BITS       = 12,
  parameter int CLK_DIV    = 24,
  parameter int GAP        = 64,
  parameter int DEBOUNCE   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset_n,
  joy_serial_multi_if.slave bus
);
  localparam int W  = PLAYERS * BITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int GW = $clog2(GAP + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PLY_LAST  = PW'(PLAYERS - 1);
  localparam logic [BW-1:0] BIT_FIRST = BW'(BITS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [3:0]    DEB_MIN   = 4'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [PW-1:0]   ply_q, ply_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [W-1:0]    raw_q, raw_d;
  logic [W-1:0]    cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    joystick_q, joystick_d;
  logic            valid_q, valid_d;
  logic            changed_q, changed_d;
  logic            load_n_q, load_n_d;
  logic            jclk_q, jclk_d;
  logic            busy_q, busy_d;

  logic            tick;
  logic            in_bit;
  logic [IW-1:0]   raw_idx;

  assign tick    = (div_q == DIV_LAST);
  // Chain bits are active-low when ACTIVE_LOW is set; store them as pressed=1.
  assign in_bit  = (ACTIVE_LOW != 0) ? ~bus.joy_data : bus.joy_data;
  assign raw_idx = IW'(ply_q) * IW'(BITS) + IW'(bit_q);

  // Next-state, datapath and registered-output decode for the scan sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DW'(1);
    ply_d      = ply_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    raw_d      = raw_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    joystick_d = joystick_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Restart the divider so LOAD lasts exactly one full tick period.
        if (bus.enable) begin
          state_d = S_LOAD;
          div_d   = '0;
        end
      end
      S_LOAD: begin
        if (tick) begin
          state_d = S_SHIFT_LO;
          ply_d   = '0;
          bit_d   = BIT_FIRST;
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          raw_d[raw_idx] = in_bit;
          state_d        = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          if (ply_q == PLY_LAST && bit_q == '0) begin
            state_d = S_LATCH;
          end else if (bit_q == '0) begin
            ply_d   = ply_q + PW'(1);
            bit_d   = BIT_FIRST;
            state_d = S_SHIFT_LO;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_LATCH: begin
        // Count consecutive identical scans; the counter saturates at 15.
        if (raw_q == cand_q) begin
          cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end else begin
          cand_d = raw_q;
          cnt_d  = 4'd1;
        end
        if (cnt_d >= DEB_MIN && joystick_q != cand_d) begin
          joystick_d = cand_d;
          changed_d  = 1'b1;
        end
        valid_d = 1'b1;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) begin
            state_d = bus.enable ? S_LOAD : S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_n_d = (state_d != S_LOAD);
    jclk_d   = (state_d == S_SHIFT_HI);
    busy_d   = (state_d == S_LOAD) || (state_d == S_SHIFT_LO) ||
               (state_d == S_SHIFT_HI) || (state_d == S_LATCH);
  end

  // Sequencer state, counters, debounce state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      ply_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      joystick_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      load_n_q   <= 1'b1;
      jclk_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ply_q      <= ply_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      joystick_q <= joystick_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      load_n_q   <= load_n_d;
      jclk_q     <= jclk_d;
      busy_q     <= busy_d;
    end
  end

  // Raw shift capture; every bit is rewritten by each scan before LATCH reads it.
  always_ff @(posedge clk) begin
    raw_q <= raw_d;
  end

  assign bus.joy_load_n = load_n_q;
  assign bus.joy_clk    = jclk_q;
  assign bus.joystick   = joystick_q;
  assign bus.valid      = valid_q;
  assign bus.changed    = changed_q;
  assign bus.scan_busy  = busy_q;
endmodule

// File: tb/tb_joy_serial_multi.sv
// Bench for joy_serial_multi: a default-parameter reader (u0) and a wide,
// fast, debounced reader (u1), each fed by a behavioural register-chain model.
module tb_joy_serial_multi;
  localparam int B0 = 12, W0 = 24;
  localparam int B1 = 16, W1 = 64;
  localparam int DEB1 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  joy_serial_multi_if #(.PLAYERS(2), .BITS(B0)) bus0 ();
  joy_serial_multi_if #(.PLAYERS(4), .BITS(B1)) bus1 ();

  joy_serial_multi #(.PLAYERS(2), .BITS(B0), .CLK_DIV(24), .GAP(64),
                     .DEBOUNCE(1), .ACTIVE_LOW(1))
    u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  joy_serial_multi #(.PLAYERS(4), .BITS(B1), .CLK_DIV(2), .GAP(4),
                     .DEBOUNCE(DEB1), .ACTIVE_LOW(1))
    u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Chain model: parallel load while load_n is low, advance on joy_clk rise.
  logic [W0-1:0] pressed0 = '0, shadow0 = '0;
  logic [W1-1:0] pressed1 = '0, shadow1 = '0;
  int idx0 = 0, idx1 = 0;
  logic jprev0 = 1'b0, jprev1 = 1'b0;

  function automatic logic chain_bit(input logic [63:0] sh, input int i,
                                     input int bits, input int w);
    int p, b;
    if (i < 0 || i >= w) return 1'b1;
    p = i / bits;
    b = bits - 1 - (i % bits);
    return ~sh[p*bits + b];
  endfunction

  always @(posedge clk) begin
    jprev0 <= bus0.joy_clk;
    if (!bus0.joy_load_n) begin
      shadow0 <= pressed0;
      idx0    <= 0;
    end else if (bus0.joy_clk && !jprev0) begin
      idx0 <= idx0 + 1;
    end
  end

  always @(posedge clk) begin
    jprev1 <= bus1.joy_clk;
    if (!bus1.joy_load_n) begin
      shadow1 <= pressed1;
      idx1    <= 0;
    end else if (bus1.joy_clk && !jprev1) begin
      idx1 <= idx1 + 1;
    end
  end

  assign bus0.joy_data = chain_bit({40'b0, shadow0}, idx0, B0, W0);
  assign bus1.joy_data = chain_bit(shadow1, idx1, B1, W1);

  // Debounce reference: output follows a value once the last DEB1 scans agree.
  logic [63:0] hist[$];
  logic [63:0] m_exp = '0;

  task automatic model1(input logic [63:0] raw, output logic [63:0] exp_j,
                        output logic exp_c);
    hist.push_back(raw);
    if (hist.size() > DEB1) void'(hist.pop_front());
    exp_c = 1'b0;
    if (hist.size() == DEB1 && hist[0] == raw && hist[1] == raw && raw != m_exp) begin
      m_exp = raw;
      exp_c = 1'b1;
    end
    exp_j = m_exp;
  endtask

  task automatic wait_valid0(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus0.valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_load0(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!bus0.joy_load_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises0(input int n, input int budget, output bit ok);
    int seen;
    logic prev;
    seen = 0;
    ok   = 1'b0;
    prev = bus0.joy_clk;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus0.joy_clk && !prev) seen++;
      prev = bus0.joy_clk;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic scan1(input logic [63:0] pat, output bit ok, output int edges);
    logic prev;
    pressed1 = pat;
    edges = 0;
    ok    = 1'b0;
    prev  = bus1.joy_clk;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus1.joy_clk && !prev) edges++;
      prev = bus1.joy_clk;
      if (bus1.valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int falls;
    reset_n = 1'b0;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus0.joy_load_n, bus0.joy_clk, bus0.valid, bus0.changed, bus0.scan_busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl0: got %b expected 10000",
               {bus0.joy_load_n, bus0.joy_clk, bus0.valid, bus0.changed, bus0.scan_busy});
    end
    n_checks++;
    if (bus0.joystick !== '0) begin
      n_fail++;
      $display("FAIL reset_joy0: got %h expected 0", bus0.joystick);
    end
    n_checks++;
    if ({bus1.joy_load_n, bus1.joy_clk, bus1.valid, bus1.changed, bus1.scan_busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl1: got %b expected 10000",
               {bus1.joy_load_n, bus1.joy_clk, bus1.valid, bus1.changed, bus1.scan_busy});
    end
    n_checks++;
    if (bus1.joystick !== '0) begin
      n_fail++;
      $display("FAIL reset_joy1: got %h expected 0", bus1.joystick);
    end
    reset_n = 1'b1;
    falls = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus0.joy_load_n || !bus1.joy_load_n) falls++;
    end
    n_checks++;
    if (falls != 0) begin
      n_fail++;
      $display("FAIL idle_no_load: got %0d load cycles expected 0", falls);
    end
  endtask

  task automatic test_default_scan;
    int lowcnt, busycnt, pulses, hr, badrun;
    logic prev;
    bit got_valid;
    pressed0 = '0;
    bus0.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus0.joy_load_n !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start: got load_n=%b expected 0", bus0.joy_load_n);
    end
    lowcnt = 0; busycnt = 0; pulses = 0; hr = 0; badrun = 0;
    prev = 1'b0;
    got_valid = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!bus0.joy_load_n) lowcnt++;
      if (bus0.scan_busy) busycnt++;
      if (bus0.joy_clk && !prev) pulses++;
      if (bus0.joy_clk) hr++;
      else if (hr > 0) begin
        if (hr != 24) badrun++;
        hr = 0;
      end
      prev = bus0.joy_clk;
      if (bus0.valid) begin
        got_valid = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!got_valid) begin
      n_fail++;
      $display("FAIL scan0_valid: got no valid expected one within 2000 cycles");
    end
    n_checks++;
    if (lowcnt != 24) begin
      n_fail++;
      $display("FAIL load_width: got %0d expected 24", lowcnt);
    end
    n_checks++;
    if (pulses != W0) begin
      n_fail++;
      $display("FAIL clk_pulses0: got %0d expected %0d", pulses, W0);
    end
    n_checks++;
    if (badrun != 0) begin
      n_fail++;
      $display("FAIL clk_high_width: got %0d bad runs expected 0", badrun);
    end
    n_checks++;
    if (busycnt != 1177) begin
      n_fail++;
      $display("FAIL scan_length: got %0d expected 1177", busycnt);
    end
    n_checks++;
    if (bus0.joystick !== '0 || bus0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_result: got joy=%h chg=%b expected 0/0", bus0.joystick, bus0.changed);
    end
    @(negedge clk);
    n_checks++;
    if (bus0.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse: got %b expected 0 one cycle later", bus0.valid);
    end
  endtask

  task automatic test_press;
    bit ok;
    pressed0 = 24'h001000;
    wait_valid0(4000, ok);
    n_checks++;
    if (!ok || bus0.joystick !== 24'h001000 || bus0.changed !== 1'b1) begin
      n_fail++;
      $display("FAIL press_first: got ok=%b joy=%h chg=%b expected 1/001000/1",
               ok, bus0.joystick, bus0.changed);
    end
    wait_valid0(4000, ok);
    n_checks++;
    if (!ok || bus0.joystick !== 24'h001000 || bus0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL press_repeat: got ok=%b joy=%h chg=%b expected 1/001000/0",
               ok, bus0.joystick, bus0.changed);
    end
  endtask

  task automatic test_reset_mid(output logic [W0-1:0] p);
    bit ok;
    pressed0 = 24'h801001;
    wait_load0(4000, ok);
    if (ok) wait_rises0(10, 1000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_reach: got timeout expected 10 joy_clk edges");
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.joystick !== '0 || {bus0.joy_load_n, bus0.joy_clk, bus0.scan_busy, bus0.valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_reset: got joy=%h ctrl=%b expected 0/1000", bus0.joystick,
               {bus0.joy_load_n, bus0.joy_clk, bus0.scan_busy, bus0.valid});
    end
    p = 24'($urandom) | 24'h000010;
    pressed0 = p;
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid0(2000, ok);
    n_checks++;
    if (!ok || bus0.joystick !== p || bus0.changed !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: got ok=%b joy=%h chg=%b expected 1/%h/1",
               ok, bus0.joystick, bus0.changed, p);
    end
  endtask

  task automatic test_enable_drop(input logic [W0-1:0] p);
    bit ok;
    int lows;
    logic [W0-1:0] q;
    q = 24'($urandom);
    pressed0 = q;
    wait_load0(4000, ok);
    if (ok) wait_rises0(5, 1000, ok);
    bus0.enable = 1'b0;
    if (ok) wait_valid0(2000, ok);
    n_checks++;
    if (!ok || bus0.joystick !== q || bus0.changed !== (q != p)) begin
      n_fail++;
      $display("FAIL drop_scan: got ok=%b joy=%h chg=%b expected 1/%h/%b",
               ok, bus0.joystick, bus0.changed, q, (q != p));
    end
    lows = 0;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk);
      if (!bus0.joy_load_n) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL drop_no_load: got %0d load cycles expected 0", lows);
    end
    n_checks++;
    if ({bus0.joy_load_n, bus0.joy_clk, bus0.scan_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL drop_idle: got %b expected 100",
               {bus0.joy_load_n, bus0.joy_clk, bus0.scan_busy});
    end
    bus0.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus0.joy_load_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable: got load_n=%b expected 0", bus0.joy_load_n);
    end
    bus0.enable = 1'b0;
  endtask

  task automatic test_wide_scan;
    bit ok;
    int edges;
    logic [63:0] ej;
    logic ec;
    hist.delete();
    m_exp = '0;
    bus1.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      scan1(64'h8000_0000_0000_0000, ok, edges);
      model1(64'h8000_0000_0000_0000, ej, ec);
      n_checks++;
      if (!ok || edges != W1) begin
        n_fail++;
        $display("FAIL wide_edges[%0d]: got ok=%b edges=%0d expected 1/%0d", k, ok, edges, W1);
      end
      n_checks++;
      if (bus1.joystick !== ej || bus1.changed !== ec) begin
        n_fail++;
        $display("FAIL wide_joy[%0d]: got %h/%b expected %h/%b", k, bus1.joystick, bus1.changed, ej, ec);
      end
    end
    n_checks++;
    if (bus1.joystick[63] !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_msb: got %b expected 1", bus1.joystick[63]);
    end
  endtask

  task automatic test_debounce;
    bit ok;
    int edges;
    logic [63:0] ej, x;
    logic [63:0] seq[9];
    logic ec;
    x = {$urandom, $urandom} | 64'h1;
    seq = '{64'h0, 64'h0, 64'h0, x, x, 64'h0, x, x, x};
    for (int k = 0; k < 9; k++) begin
      scan1(seq[k], ok, edges);
      model1(seq[k], ej, ec);
      n_checks++;
      if (!ok || bus1.joystick !== ej || bus1.changed !== ec) begin
        n_fail++;
        $display("FAIL debounce[%0d]: got ok=%b joy=%h chg=%b expected 1/%h/%b",
                 k, ok, bus1.joystick, bus1.changed, ej, ec);
      end
      if (k == 5) begin
        n_checks++;
        if (bus1.joystick !== 64'h0) begin
          n_fail++;
          $display("FAIL debounce_glitch: got %h expected 0", bus1.joystick);
        end
      end
    end
    n_checks++;
    if (bus1.joystick !== x) begin
      n_fail++;
      $display("FAIL debounce_hold: got %h expected %h", bus1.joystick, x);
    end
  endtask

  task automatic test_random;
    bit ok;
    int edges, run;
    logic [63:0] ej, pat;
    logic ec;
    run = 0;
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      if (run == 0) begin
        pat = {$urandom, $urandom};
        run = $urandom_range(1, 4);
      end
      run--;
      scan1(pat, ok, edges);
      model1(pat, ej, ec);
      n_checks++;
      if (!ok || bus1.joystick !== ej || bus1.changed !== ec) begin
        n_fail++;
        $display("FAIL random[%0d]: got ok=%b joy=%h chg=%b expected 1/%h/%b",
                 k, ok, bus1.joystick, bus1.changed, ej, ec);
      end
    end
    bus1.enable = 1'b0;
  endtask

  initial begin
    logic [W0-1:0] p;
    bus0.enable = 1'b0;
    bus1.enable = 1'b0;
    test_reset();
    test_default_scan();
    test_press();
    test_reset_mid(p);
    test_enable_drop(p);
    test_wide_scan();
    test_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
